// File: rtl/input_conditioner_if.sv
// Board-side input bundle for the input conditioner: raw pins in, clean levels/pulses out.
interface input_conditioner_if;
  logic [6:0] raw_keys;
  logic       raw_next;
  logic       raw_prev;
  logic [6:0] key_level;
  logic [6:0] key_press;
  logic       next_pulse;
  logic       prev_pulse;
  logic       busy;

  modport master (
    output raw_keys, raw_next, raw_prev,
    input  key_level, key_press, next_pulse, prev_pulse, busy
  );

  modport slave (
    input  raw_keys, raw_next, raw_prev,
    output key_level, key_press, next_pulse, prev_pulse, busy
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces 7 note keys plus next/prev song buttons, producing
// stable key levels, per-key press pulses and arbitrated song-select pulses.
module ic_channel #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic active_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any disagreement that does not persist for the full window restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == LAST) stable_d = sync_q;
      else               cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // rise_o is the next-state edge so the registered pulse lines up with the level.
  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;
  assign active_o = |cnt_q;
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic                clk,
  input  logic                reset,
  input_conditioner_if.slave  io
);
  localparam int NUM_CH = 9;

  logic [NUM_CH-1:0] raw, stable, rise, active;
  logic [6:0]        key_press_q;
  logic              next_pulse_q, next_pulse_d;
  logic              prev_pulse_q, prev_pulse_d;
  logic              busy_q;

  assign raw = {io.raw_prev, io.raw_next, io.raw_keys};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    ic_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw[ch]),
      .stable_o(stable[ch]),
      .rise_o  (rise[ch]),
      .active_o(active[ch])
    );
  end

  // Simultaneous next/prev is ambiguous, so the event is dropped entirely.
  assign next_pulse_d = rise[7] & ~rise[8];
  assign prev_pulse_d = rise[8] & ~rise[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_press_q  <= '0;
      next_pulse_q <= 1'b0;
      prev_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      key_press_q  <= rise[6:0];
      next_pulse_q <= next_pulse_d;
      prev_pulse_q <= prev_pulse_d;
      busy_q       <= |active;
    end
  end

  assign io.key_level  = stable[6:0];
  assign io.key_press  = key_press_q;
  assign io.next_pulse = next_pulse_q;
  assign io.prev_pulse = prev_pulse_q;
  assign io.busy       = busy_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int         cyc;
    logic [6:0] kp;
    logic       np;
    logic       pp;
  } exp_t;
  exp_t sb[$];

  input_conditioner_if ifc();

  input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push(int c, logic [6:0] kp, logic np, logic pp);
    exp_t e;
    e.cyc = c; e.kp = kp; e.np = np; e.pp = pp;
    sb.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (|ifc.key_press || ifc.next_pulse || ifc.prev_pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({ifc.key_press, ifc.next_pulse, ifc.prev_pulse}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("key_press", 32'(ifc.key_press), 32'(e.kp));
        chk("next_pulse", 32'(ifc.next_pulse), 32'(e.np));
        chk("prev_pulse", 32'(ifc.prev_pulse), 32'(e.pp));
      end
    end
  end

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(string name);
    chk(name, 32'({ifc.key_level, ifc.key_press, ifc.next_pulse, ifc.prev_pulse, ifc.busy}), 32'd0);
  endtask

  initial begin
    int  c;
    logic busy_seen;
    ifc.raw_keys = '0;
    ifc.raw_next = 1'b0;
    ifc.raw_prev = 1'b0;

    wait_neg(3);
    chk_all_zero("reset_state");
    reset = 1'b0;
    wait_neg(2);

    // 1. clean press of key 0
    ifc.raw_keys[0] = 1'b1;
    c = cyc;
    push(c + 6, 7'h01, 1'b0, 1'b0);
    wait_neg(5);
    chk("t1_level_early", 32'(ifc.key_level), 32'h00);
    wait_neg(1);
    chk("t1_level_flip", 32'(ifc.key_level), 32'h01);
    wait_neg(10);
    chk("t1_level_held", 32'(ifc.key_level), 32'h01);
    ifc.raw_keys[0] = 1'b0;
    wait_neg(6);
    chk("t1_level_release", 32'(ifc.key_level), 32'h00);
    wait_neg(4);

    // 2. bouncing next button never settles
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifc.raw_next = (i % 2 == 0);
      @(negedge clk);
      if (ifc.busy) busy_seen = 1'b1;
    end
    ifc.raw_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.busy) busy_seen = 1'b1;
    end
    chk("t2_busy_seen", 32'(busy_seen), 32'd1);
    chk("t2_busy_idle", 32'(ifc.busy), 32'd0);
    chk("t2_key_level", 32'(ifc.key_level), 32'h00);

    // 3. prev bounces then settles high
    for (int i = 0; i < 4; i++) begin
      ifc.raw_prev = (i % 2 == 0);
      @(negedge clk);
    end
    ifc.raw_prev = 1'b1;
    c = cyc;
    push(c + 6, 7'h00, 1'b0, 1'b1);
    wait_neg(12);
    ifc.raw_prev = 1'b0;
    wait_neg(10);

    // 4. next and prev together are dropped; next alone afterwards still works
    ifc.raw_next = 1'b1;
    ifc.raw_prev = 1'b1;
    wait_neg(6);
    chk("t4_both_dropped", 32'({ifc.next_pulse, ifc.prev_pulse}), 32'd0);
    wait_neg(6);
    ifc.raw_next = 1'b0;
    ifc.raw_prev = 1'b0;
    wait_neg(10);
    ifc.raw_next = 1'b1;
    c = cyc;
    push(c + 6, 7'h00, 1'b1, 1'b0);
    wait_neg(10);
    ifc.raw_next = 1'b0;
    wait_neg(10);

    // 5. multi-key press and release
    ifc.raw_keys = 7'b1010101;
    c = cyc;
    push(c + 6, 7'b1010101, 1'b0, 1'b0);
    wait_neg(6);
    chk("t5_level_press", 32'(ifc.key_level), 32'h55);
    wait_neg(6);
    ifc.raw_keys = 7'b0000000;
    wait_neg(5);
    chk("t5_level_before_rel", 32'(ifc.key_level), 32'h55);
    wait_neg(1);
    chk("t5_level_released", 32'(ifc.key_level), 32'h00);
    wait_neg(4);

    // 6. reset mid-debounce on key 3
    ifc.raw_keys[3] = 1'b1;
    wait_neg(4);
    chk("t6_busy_before_rst", 32'(ifc.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_reset_async");
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    push(c + 6, 7'h08, 1'b0, 1'b0);
    wait_neg(5);
    chk("t6_level_early", 32'(ifc.key_level), 32'h00);
    wait_neg(1);
    chk("t6_level_flip", 32'(ifc.key_level), 32'h08);
    wait_neg(4);
    ifc.raw_keys[3] = 1'b0;
    wait_neg(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
